// File: rtl/fmul_arbiter_if.sv
// Requester-side bundle for fmul_arbiter: per-requester request and response
// handshakes. Operands and results are packed 32 bits per requester.
interface fmul_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_op1;
  logic [32*NUM_REQ-1:0] req_op2;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [NUM_REQ-1:0]    resp_ready;
  logic [32*NUM_REQ-1:0] resp_result;

  modport master (
    output req_valid, req_op1, req_op2, resp_ready,
    input  req_ready, resp_valid, resp_result
  );

  modport slave (
    input  req_valid, req_op1, req_op2, resp_ready,
    output req_ready, resp_valid, resp_result
  );
endinterface

// File: rtl/fmul_arbiter.sv
// Shares one pipelined fmul among NUM_REQ requesters with per-requester result buffers.
// Round-robin by default; define FMUL_ARB_FIXPRI_EN for fixed priority (lowest index wins).
module fmul_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int FMUL_LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  fmul_arbiter_if.slave bus,
  output logic [31:0]   fmul_op1,
  output logic [31:0]   fmul_op2,
  input  logic [31:0]   fmul_result
);
  localparam int IDX_W = $clog2(NUM_REQ);
  // Tag stage 0 sits alongside the issue register, so one stage beyond the fmul depth
  localparam int TAG_STAGES = FMUL_LATENCY + 1;
  localparam int LAST = TAG_STAGES - 1;

  logic [NUM_REQ-1:0]    busy;
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic [NUM_REQ-1:0]    resp_valid_q;
  logic [32*NUM_REQ-1:0] resp_result_q;
  logic                  tag_v   [TAG_STAGES];
  logic [IDX_W-1:0]      tag_idx [TAG_STAGES];

  assign eligible        = bus.req_valid & ~busy;
  assign bus.req_ready   = grant;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = resp_result_q;

`ifdef FMUL_ARB_FIXPRI_EN
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      if (eligible[k-1]) begin
        grant        = '0;
        grant[k-1]   = 1'b1;
        grant_idx    = IDX_W'(k - 1);
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr;
  int unsigned      cand;

  // Descending scan so the smallest offset from the pointer is the final winner
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      cand = 32'(ptr) + k - 1;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (eligible[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (|grant) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy          <= '0;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      fmul_op1      <= '0;
      fmul_op2      <= '0;
      for (int unsigned s = 0; s < TAG_STAGES; s++) begin
        tag_v[s]   <= 1'b0;
        tag_idx[s] <= '0;
      end
    end else begin
      busy <= (busy | grant) & ~(resp_valid_q & bus.resp_ready);
      if (|grant) begin
        fmul_op1 <= bus.req_op1[32*grant_idx +: 32];
        fmul_op2 <= bus.req_op2[32*grant_idx +: 32];
      end
      tag_v[0]   <= |grant;
      tag_idx[0] <= grant_idx;
      for (int unsigned s = 1; s < TAG_STAGES; s++) begin
        tag_v[s]   <= tag_v[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end
      // A slot is always empty when its result lands, so set after clear is safe
      resp_valid_q <= resp_valid_q & ~bus.resp_ready;
      if (tag_v[LAST]) begin
        resp_valid_q[tag_idx[LAST]]             <= 1'b1;
        resp_result_q[32*tag_idx[LAST] +: 32]   <= fmul_result;
      end
    end
  end
endmodule

// File: tb/tb_fmul_arbiter.sv
// Scoreboard bench for fmul_arbiter with a behavioural fmul stub and grant/latency model.
module tb_fmul_arbiter;
  localparam int NR  = 4;
  localparam int LAT = 2;

  typedef struct packed { logic [31:0] a; logic [31:0] b; logic [31:0] r; } op_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fmul_op1, fmul_op2, fmul_result;
  logic [31:0] pipe [LAT];

  fmul_arbiter_if #(.NUM_REQ(NR)) bus ();

  fmul_arbiter #(.NUM_REQ(NR), .FMUL_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .fmul_op1(fmul_op1), .fmul_op2(fmul_op2), .fmul_result(fmul_result)
  );

  always #5 clk = ~clk;

  // Simple normal-range single-precision multiply (truncating)
  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
    e = {2'b0, x[30:23]} + {2'b0, y[30:23]} - 10'd127;
    if (p[47]) begin m = p[46:24]; e = e + 10'd1; end
    else m = p[45:23];
    return {x[31] ^ y[31], e[7:0], m};
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    op_t o;
    o.a = a; o.b = b; o.r = r;
    return o;
  endfunction

  always @(posedge clk) begin
    pipe[0] <= fp_mul(fmul_op1, fmul_op2);
    for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
  end
  assign fmul_result = pipe[LAT-1];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  op_t          stim_q [NR][$];
  op_t          cur    [NR];
  logic [31:0]  exp_q  [NR][$];
  int           acc_cnt [NR];
  int           seen_cnt[NR];
  int           acc_cyc [NR];
  int           rdy_mode[NR];
  int           auto_req[NR];
  logic [NR-1:0] outst;
  int           rr_ptr;
  int           gnt_log[$];
  int           gcyc_log[$];

  // Driver: each requester presents one operation at a time and holds it until accepted
  initial begin
    bus.req_valid  = '0;
    bus.resp_ready = '0;
    bus.req_op1    = '0;
    bus.req_op2    = '0;
    for (int i = 0; i < NR; i++) begin
      rdy_mode[i] = 0; auto_req[i] = 0; acc_cnt[i] = 0; seen_cnt[i] = 0;
    end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (acc_cnt[i] != seen_cnt[i]) begin
          seen_cnt[i] = acc_cnt[i];
          bus.req_valid[i] = 1'b0;
        end
        if (!reset) bus.req_valid[i] = 1'b0;
        else if (!bus.req_valid[i]) begin
          op_t o;
          bit  go;
          go = 1'b0;
          if (stim_q[i].size() > 0) begin o = stim_q[i].pop_front(); go = 1'b1; end
          else if (auto_req[i] == 2 || (auto_req[i] == 1 && $urandom_range(0, 3) != 0)) begin
            o.a = rand_fp(); o.b = rand_fp(); o.r = fp_mul(o.a, o.b); go = 1'b1;
          end
          if (go) begin
            cur[i] = o;
            bus.req_op1[32*i +: 32] = o.a;
            bus.req_op2[32*i +: 32] = o.b;
            bus.req_valid[i] = 1'b1;
          end
        end
        bus.resp_ready[i] = (rdy_mode[i] == 1) ? 1'b1 :
                            (rdy_mode[i] == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  // Monitor: grant model, issue-operand check, result scoreboard, latency and hold checks
  logic [NR-1:0] prev_rv, prev_cons, exp_g;
  logic [31:0]   prev_res [NR];
  bit            pend;
  logic [31:0]   pend_a, pend_b;
  int            gi, c;

  always @(negedge clk) begin
    if (!reset) begin
      outst = '0; rr_ptr = 0; prev_rv = '0; prev_cons = '0; pend = 1'b0;
      for (int i = 0; i < NR; i++) exp_q[i].delete();
    end else begin
      exp_g = '0; gi = -1;
      for (int k = NR - 1; k >= 0; k--) begin
        c = (rr_ptr + k) % NR;
        if (bus.req_valid[c] && !outst[c]) begin exp_g = '0; exp_g[c] = 1'b1; gi = c; end
      end
      check(bus.req_ready == exp_g, "grant", 32'(bus.req_ready), 32'(exp_g));
      if (pend) begin
        check(fmul_op1 == pend_a, "fmul_op1", fmul_op1, pend_a);
        check(fmul_op2 == pend_b, "fmul_op2", fmul_op2, pend_b);
        pend = 1'b0;
      end
      if (gi >= 0) begin
        outst[gi] = 1'b1;
        exp_q[gi].push_back(cur[gi].r);
        acc_cyc[gi] = cyc + 1;
        pend = 1'b1; pend_a = cur[gi].a; pend_b = cur[gi].b;
        acc_cnt[gi]++;
        gnt_log.push_back(gi);
        gcyc_log.push_back(cyc + 1);
`ifndef FMUL_ARB_FIXPRI_EN
        rr_ptr = (gi + 1) % NR;
`endif
      end
      for (int i = 0; i < NR; i++) begin
        if (prev_rv[i] && !prev_cons[i])
          check(bus.resp_valid[i], "resp_held", 32'(bus.resp_valid[i]), 32'd1);
        if (bus.resp_valid[i]) begin
          if (!prev_rv[i]) begin
            if (exp_q[i].size() == 0) check(1'b0, "stale_result", 32'(i), 32'hFFFF_FFFF);
            else begin
              check(cyc - acc_cyc[i] == LAT + 1, "latency", 32'(cyc - acc_cyc[i]), 32'(LAT + 1));
              check(bus.resp_result[32*i +: 32] == exp_q[i][0], "result",
                    bus.resp_result[32*i +: 32], exp_q[i][0]);
            end
          end else
            check(bus.resp_result[32*i +: 32] == prev_res[i], "result_stable",
                  bus.resp_result[32*i +: 32], prev_res[i]);
          if (bus.resp_ready[i]) begin
            if (exp_q[i].size() > 0) void'(exp_q[i].pop_front());
            outst[i] = 1'b0;
          end
        end
        prev_res[i] = bus.resp_result[32*i +: 32];
      end
      prev_rv   = bus.resp_valid;
      prev_cons = bus.resp_valid & bus.resp_ready;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    int  pending;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      tick();
      pending = 0;
      for (int i = 0; i < NR; i++) pending += stim_q[i].size();
      if (outst == '0 && pending == 0 && bus.req_valid == '0) done = 1'b1;
    end
    if (!done) check(1'b0, "idle_timeout", 32'(outst), 32'd0);
  endtask

  task automatic pulse_reset();
    tick(); reset = 1'b0; tick(); tick(); reset = 1'b1;
  endtask

  task automatic set_all(input int rdy, input int au);
    for (int i = 0; i < NR; i++) begin rdy_mode[i] = rdy; auto_req[i] = au; end
  endtask

  initial begin
    int viol, total, others, base;
    repeat (3) @(posedge clk);
    #1;
    check(bus.resp_valid == '0, "reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    check(fmul_op1 == 32'h0, "reset_fmul_op1", fmul_op1, 32'h0);
    check(bus.resp_result == '0, "reset_resp_result", bus.resp_result[31:0], 32'h0);
    reset = 1'b1;

    // Single request, then a second one queued right behind it
    rdy_mode[0] = 1;
    stim_q[0].push_back(mk(32'h3F800000, 32'h40000000, 32'h40000000));
    stim_q[0].push_back(mk(32'h40400000, 32'h3F800000, 32'h40400000));
    wait_idle(60);
    check(gcyc_log.size() == 2, "t1_accepts", 32'(gcyc_log.size()), 32'd2);
    if (gcyc_log.size() == 2)
      check(gcyc_log[1] - gcyc_log[0] == LAT + 3, "t1_reaccept_gap",
            32'(gcyc_log[1] - gcyc_log[0]), 32'(LAT + 3));

    // Contention from pointer 0
    pulse_reset();
    gnt_log.delete(); gcyc_log.delete();
    set_all(1, 0);
    stim_q[0].push_back(mk(32'h3FC00000, 32'h3FC00000, 32'h40100000));
    stim_q[1].push_back(mk(32'h40400000, 32'hC0000000, 32'hC0C00000));
    stim_q[2].push_back(mk(32'h40000000, 32'h40000000, 32'h40800000));
    stim_q[3].push_back(mk(32'h3F800000, 32'h3F800000, 32'h3F800000));
    wait_idle(60);
    check(gnt_log.size() == 4, "t2_grants", 32'(gnt_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < gnt_log.size(); k++) begin
      check(gnt_log[k] == k, "t2_order", 32'(gnt_log[k]), 32'(k));
      if (k > 0) check(gcyc_log[k] == gcyc_log[k-1] + 1, "t2_consecutive",
                       32'(gcyc_log[k] - gcyc_log[k-1]), 32'd1);
    end

    // Requester 1 withholds resp_ready while others keep running
    gnt_log.delete(); gcyc_log.delete();
    set_all(1, 1);
    rdy_mode[1] = 0; auto_req[1] = 0;
    stim_q[1].push_back(mk(32'h40A00000, 32'h40000000, 32'h41200000));
    stim_q[1].push_back(mk(32'h3F000000, 32'h40800000, 32'h40000000));
    repeat (20) tick();
    check(bus.resp_valid[1], "t3_held_valid", 32'(bus.resp_valid[1]), 32'd1);
    check(bus.resp_result[63:32] == 32'h41200000, "t3_held_result", bus.resp_result[63:32], 32'h41200000);
    check(bus.req_valid[1] && !bus.req_ready[1], "t3_blocked", 32'(bus.req_ready[1]), 32'd0);
    others = 0;
    foreach (gnt_log[k]) if (gnt_log[k] != 1) others++;
    check(others >= 6, "t3_others_served", 32'(others), 32'd6);
    rdy_mode[1] = 2;
    set_all(2, 0);
    wait_idle(200);

    // Fairness between requesters 0 and 2
    pulse_reset();
    gnt_log.delete(); gcyc_log.delete();
    set_all(1, 0);
    auto_req[0] = 2; auto_req[2] = 2;
    repeat (40) tick();
    auto_req[0] = 0; auto_req[2] = 0;
    wait_idle(60);
    viol = 0;
    for (int k = 1; k < gnt_log.size(); k++) if (gnt_log[k] == gnt_log[k-1]) viol++;
    check(gnt_log.size() >= 8, "t4_grant_count", 32'(gnt_log.size()), 32'd8);
    check(viol == 0, "t4_alternate", 32'(viol), 32'd0);
    if (gnt_log.size() > 0) check(gnt_log[0] == 0, "t4_first", 32'(gnt_log[0]), 32'd0);

    // Randomised traffic with random consumer stalls
    set_all(2, 1);
    repeat (400) tick();
    set_all(1, 0);
    wait_idle(300);

    // Reset with three operations in flight
    set_all(1, 0);
    base = 0;
    for (int i = 0; i < NR; i++) base += acc_cnt[i];
    for (int i = 0; i < 3; i++) stim_q[i].push_back(mk(rand_fp(), rand_fp(), 32'h0));
    total = base;
    for (int n = 0; n < 30 && total < base + 3; n++) begin
      @(negedge clk);
      total = 0;
      for (int i = 0; i < NR; i++) total += acc_cnt[i];
    end
    check(total == base + 3, "t5_three_accepted", 32'(total - base), 32'd3);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check(bus.resp_valid == '0, "t5_async_resp_valid", 32'(bus.resp_valid), 32'd0);
    check(fmul_op1 == 32'h0, "t5_async_fmul_op1", fmul_op1, 32'h0);
    check(fmul_op2 == 32'h0, "t5_async_fmul_op2", fmul_op2, 32'h0);
    for (int i = 0; i < NR; i++) stim_q[i].delete();
    tick(); tick();
    reset = 1'b1;
    viol = 0;
    for (int n = 0; n < LAT + 8; n++) begin
      tick();
      if (bus.resp_valid != '0) viol++;
    end
    check(viol == 0, "t5_no_stale", 32'(viol), 32'd0);
    gnt_log.delete(); gcyc_log.delete();
    stim_q[3].push_back(mk(32'h40000000, 32'h40400000, 32'h40C00000));
    stim_q[0].push_back(mk(32'h40800000, 32'h3F000000, 32'h40000000));
    wait_idle(60);
    if (gnt_log.size() > 0) check(gnt_log[0] == 0, "t5_ptr_restart", 32'(gnt_log[0]), 32'd0);
    else check(1'b0, "t5_ptr_restart", 32'hFFFF_FFFF, 32'd0);

    total = 0;
    for (int i = 0; i < NR; i++) total += exp_q[i].size();
    check(total == 0, "drain", 32'(total), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
